// File: rtl/rgb2gray_pipe.sv
// Multi-lane RGB-to-gray converter: programmable luma coefficients, passthrough and max modes.
// Define RGB2GRAY_PIPE_SKID_EN to add a 2-entry output skid buffer with a registered ready_o.
module rgb2gray_pipe #(
    parameter int WIDTH_P  = 8,
    parameter int LANES_P  = 1,
    parameter int COEF_W_P = 8
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [LANES_P*WIDTH_P-1:0]   red_i,
    input  logic [LANES_P*WIDTH_P-1:0]   green_i,
    input  logic [LANES_P*WIDTH_P-1:0]   blue_i,
    input  logic [1:0]                   mode_i,
    input  logic                         coef_load_i,
    input  logic [COEF_W_P-1:0]          coef_r_i,
    input  logic [COEF_W_P-1:0]          coef_g_i,
    input  logic [COEF_W_P-1:0]          coef_b_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [LANES_P*WIDTH_P-1:0]   gray_o,
    output logic                         busy_o
);

    localparam int  PW    = WIDTH_P + COEF_W_P;
    localparam int  SW    = PW + 2;
    localparam int  LW    = LANES_P * WIDTH_P;
    localparam int  HALF  = 1 << (COEF_W_P - 1);
    localparam real SCALE = 2.0 ** COEF_W_P;

    // Green absorbs the rounding error so the coefficients sum to exactly one.
    localparam int DEF_R_I = $rtoi(0.299 * SCALE + 0.5);
    localparam int DEF_B_I = $rtoi(0.114 * SCALE + 0.5);
    localparam int DEF_G_I = (1 << COEF_W_P) - DEF_R_I - DEF_B_I;

    localparam logic [COEF_W_P-1:0] DEF_R = COEF_W_P'(DEF_R_I);
    localparam logic [COEF_W_P-1:0] DEF_G = COEF_W_P'(DEF_G_I);
    localparam logic [COEF_W_P-1:0] DEF_B = COEF_W_P'(DEF_B_I);

    logic                en;
    logic                valid_s1;
    logic                valid_s2;
    logic [1:0]          mode_s1;
    logic [COEF_W_P-1:0] coef_r;
    logic [COEF_W_P-1:0] coef_g;
    logic [COEF_W_P-1:0] coef_b;
    logic [LW-1:0]       gray_s2;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            coef_r <= DEF_R;
            coef_g <= DEF_G;
            coef_b <= DEF_B;
        end else if (coef_load_i) begin
            coef_r <= coef_r_i;
            coef_g <= coef_g_i;
            coef_b <= coef_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            mode_s1  <= 2'd0;
        end else if (en) begin
            valid_s1 <= valid_i;
            valid_s2 <= valid_s1;
            if (valid_i) begin
                mode_s1 <= mode_i;
            end
        end
    end

    for (genvar k = 0; k < LANES_P; k++) begin : g_lane
        logic [WIDTH_P-1:0] r_in;
        logic [WIDTH_P-1:0] g_in;
        logic [WIDTH_P-1:0] b_in;
        logic [PW-1:0]      pr;
        logic [PW-1:0]      pg;
        logic [PW-1:0]      pb;
        logic [WIDTH_P-1:0] r;
        logic [WIDTH_P-1:0] g;
        logic [WIDTH_P-1:0] b;
        logic [SW-1:0]      sum;
        logic [SW-1:0]      shifted;
        logic [WIDTH_P-1:0] luma;
        logic [WIDTH_P-1:0] max_rg;
        logic [WIDTH_P-1:0] max_rgb;
        logic [WIDTH_P-1:0] res;
        logic [WIDTH_P-1:0] gray_q;

        assign r_in = red_i[k*WIDTH_P +: WIDTH_P];
        assign g_in = green_i[k*WIDTH_P +: WIDTH_P];
        assign b_in = blue_i[k*WIDTH_P +: WIDTH_P];

        // Products, not coefficients, travel down the pipe.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                pr <= '0;
                pg <= '0;
                pb <= '0;
                r  <= '0;
                g  <= '0;
                b  <= '0;
            end else if (en && valid_i) begin
                pr <= PW'(r_in) * PW'(coef_r);
                pg <= PW'(g_in) * PW'(coef_g);
                pb <= PW'(b_in) * PW'(coef_b);
                r  <= r_in;
                g  <= g_in;
                b  <= b_in;
            end
        end

        assign sum     = SW'(pr) + SW'(pg) + SW'(pb) + SW'(HALF);
        assign shifted = sum >> COEF_W_P;
        assign luma    = (|shifted[SW-1:WIDTH_P]) ? '1 : shifted[WIDTH_P-1:0];
        assign max_rg  = (r > g) ? r : g;
        assign max_rgb = (max_rg > b) ? max_rg : b;

        always_comb begin
            res = luma;
            case (mode_s1)
                2'd0: res = luma;
                2'd1: res = r;
                2'd2: res = g;
                2'd3: res = max_rgb;
            endcase
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                gray_q <= '0;
            end else if (en && valid_s1) begin
                gray_q <= res;
            end
        end

        assign gray_s2[k*WIDTH_P +: WIDTH_P] = gray_q;
    end

`ifdef RGB2GRAY_PIPE_SKID_EN
    logic [LW-1:0] skid_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          full_q;
    logic          push;
    logic          pop;

    // S2 drains every enabled cycle: straight out when possible, else into the skid.
    assign en         = !full_q;
    assign ready_o    = !full_q;
    assign pop        = (count != 2'd0) && ready_i;
    assign push       = en && valid_s2 && !((count == 2'd0) && ready_i);
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count  <= count_next;
            full_q <= (count_next == 2'd2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            skid_mem[wr_ptr] <= gray_s2;
        end
    end

    assign valid_o = (count != 2'd0) || valid_s2;
    assign gray_o  = (count != 2'd0) ? skid_mem[rd_ptr] : gray_s2;
    assign busy_o  = valid_s1 || valid_s2 || (count != 2'd0);
`else
    assign en      = !valid_s2 || ready_i;
    assign ready_o = en;
    assign valid_o = valid_s2;
    assign gray_o  = gray_s2;
    assign busy_o  = valid_s1 || valid_s2;
`endif

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed self-checking bench for rgb2gray_pipe with four lanes.
module tb_rgb2gray_pipe;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] red_i;
    logic [31:0] green_i;
    logic [31:0] blue_i;
    logic [1:0]  mode_i;
    logic        coef_load_i;
    logic [7:0]  coef_r_i;
    logic [7:0]  coef_g_i;
    logic [7:0]  coef_b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] gray_o;
    logic        busy_o;

    int total = 0;
    int passed = 0;

    rgb2gray_pipe #(
        .WIDTH_P (8),
        .LANES_P (4),
        .COEF_W_P(8)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .red_i      (red_i),
        .green_i    (green_i),
        .blue_i     (blue_i),
        .mode_i     (mode_i),
        .coef_load_i(coef_load_i),
        .coef_r_i   (coef_r_i),
        .coef_g_i   (coef_g_i),
        .coef_b_i   (coef_b_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .gray_o     (gray_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic load(input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
        coef_load_i = 1'b1;
        coef_r_i = cr;
        coef_g_i = cg;
        coef_b_i = cb;
        tick();
        coef_load_i = 1'b0;
    endtask

    // One beat, then expect the result two edges after acceptance.
    task automatic beat(input string tag, input logic [31:0] r, input logic [31:0] g,
                        input logic [31:0] b, input logic [1:0] m, input logic [31:0] exp);
        valid_i = 1'b1;
        red_i = r;
        green_i = g;
        blue_i = b;
        mode_i = m;
        tick();
        valid_i = 1'b0;
        tick();
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk(tag, gray_o, exp);
        tick();
    endtask

    int          idx;
    int          got;
    logic        acc;
    logic        prev_stall;
    logic [31:0] prev_gray;

    initial begin
        rstn_i = 1'b1;
        valid_i = 1'b0;
        red_i = '0;
        green_i = '0;
        blue_i = '0;
        mode_i = 2'd0;
        coef_load_i = 1'b0;
        coef_r_i = '0;
        coef_g_i = '0;
        coef_b_i = '0;
        ready_i = 1'b1;
        #2;
        do_reset();

        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_gray", gray_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);

        // Latency: not valid one edge after acceptance
        valid_i = 1'b1;
        red_i = {4{8'd200}};
        green_i = {4{8'd200}};
        blue_i = {4{8'd200}};
        tick();
        valid_i = 1'b0;
        chk("lat1_valid", {31'd0, valid_o}, 32'd0);
        chk("lat1_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("def200_valid", {31'd0, valid_o}, 32'd1);
        chk("def200", gray_o, {4{8'd200}});
        tick();
        chk("drain_valid", {31'd0, valid_o}, 32'd0);

        beat("def_red", {4{8'd255}}, 32'd0, 32'd0, 2'd0, {4{8'd77}});

        // Backpressure: beats 1..6, ready_i low for cycles 3-7
        idx = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_gray = '0;
        for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
            ready_i = !(cyc >= 3 && cyc <= 7);
            if (idx < 6) begin
                valid_i = 1'b1;
                red_i = {4{8'(idx + 1)}};
                green_i = {4{8'(idx + 1)}};
                blue_i = {4{8'(idx + 1)}};
            end else begin
                valid_i = 1'b0;
            end
            mode_i = 2'd0;
            #1;
            if (prev_stall) begin
                chk("bp_hold_gray", gray_o, prev_gray);
                chk("bp_hold_valid", {31'd0, valid_o}, 32'd1);
            end
            if (valid_o && !ready_i) begin
                chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
            end
            if (valid_o && ready_i) begin
                got++;
                chk("bp_order", gray_o, {4{8'(got)}});
            end
            acc = valid_i && ready_o;
            prev_stall = valid_o && !ready_i;
            prev_gray = gray_o;
            tick();
            if (acc) idx++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("bp_count", got, 32'd6);
        tick();
        chk("bp_empty", {31'd0, busy_o}, 32'd0);

        // Modes across four independent lanes
        beat("mode_max", {8'd255, 8'd0, 8'd90, 8'd10}, {8'd1, 8'd0, 8'd5, 8'd20},
             {8'd2, 8'd0, 8'd5, 8'd30}, 2'd3, {8'd255, 8'd0, 8'd90, 8'd30});
        beat("mode_red", {8'd255, 8'd0, 8'd90, 8'd10}, {8'd1, 8'd0, 8'd5, 8'd20},
             {8'd2, 8'd0, 8'd5, 8'd30}, 2'd1, {8'd255, 8'd0, 8'd90, 8'd10});
        beat("mode_green", {8'd255, 8'd0, 8'd90, 8'd10}, {8'd1, 8'd0, 8'd5, 8'd20},
             {8'd2, 8'd0, 8'd5, 8'd30}, 2'd2, {8'd1, 8'd0, 8'd5, 8'd20});

        load(8'd255, 8'd255, 8'd255);
        beat("saturate", {4{8'd255}}, {4{8'd255}}, {4{8'd255}}, 2'd0, {4{8'd255}});

        load(8'd128, 8'd0, 8'd0);
        beat("round", {4{8'd3}}, {4{8'd9}}, {4{8'd9}}, 2'd0, {4{8'd2}});

        // Coefficient load coincident with beat A
        do_reset();
        valid_i = 1'b1;
        red_i = '0;
        green_i = {4{8'd100}};
        blue_i = '0;
        mode_i = 2'd0;
        coef_load_i = 1'b1;
        coef_r_i = 8'd0;
        coef_g_i = 8'd255;
        coef_b_i = 8'd0;
        tick();
        coef_load_i = 1'b0;
        tick();
        valid_i = 1'b0;
        chk("coef_a", gray_o, {4{8'd59}});
        tick();
        chk("coef_b", gray_o, {4{8'd100}});
        tick();

        // Reset with both stages full after a coefficient load
        load(8'd0, 8'd0, 8'd0);
        valid_i = 1'b1;
        red_i = {4{8'd255}};
        green_i = '0;
        blue_i = '0;
        tick();
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        ready_i = 1'b1;
        tick();
        rstn_i = 1'b1;
        tick();
        beat("post_rst", {4{8'd255}}, 32'd0, 32'd0, 2'd0, {4{8'd77}});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
- Parametrised, pipelined successor to the single-lane shift-approximation RGB-to-grayscale converter.
- Converts LANES_P pixels per beat using runtime-programmable fixed-point luma coefficients, with round-to-nearest and saturation.
- Adds per-beat mode selection: luma, channel passthrough, or max-of-channels.
- Sits between the pixel source and the Sobel line buffer on a valid/ready stream.

Parameters:
- WIDTH_P, 8, bits per colour channel and per gray output.
- LANES_P, 1, pixels processed per beat.
- COEF_W_P, 8, coefficient width; coefficients are unsigned fractions scaled by 2^COEF_W_P.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- red_i  in  LANES_P*WIDTH_P  red, lane k at [k*WIDTH_P +: WIDTH_P]
- green_i  in  LANES_P*WIDTH_P  green, same packing as red_i
- blue_i  in  LANES_P*WIDTH_P  blue, same packing as red_i
- mode_i  in  2  per-beat mode: 0 luma, 1 red, 2 green, 3 max(r,g,b)
- coef_load_i  in  1  one-cycle strobe that loads new coefficients
- coef_r_i  in  COEF_W_P  red coefficient
- coef_g_i  in  COEF_W_P  green coefficient
- coef_b_i  in  COEF_W_P  blue coefficient
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream ready
- gray_o  out  LANES_P*WIDTH_P  gray result, same lane packing as inputs
- busy_o  out  1  high when any pipeline stage holds data

Behaviour:
- Clock and reset: single clock clk_i; reset rstn_i is asynchronous and active-low.
- Reset values:
  - valid_o=0, gray_o=0, busy_o=0, all stage valids=0.
  - Coefficients = round(0.299/0.587/0.114 * 2^COEF_W_P), with green adjusted so the three sum to exactly 2^COEF_W_P. For COEF_W_P=8 this gives 77/150/29.
  - Reset mid-operation drops all in-flight beats and restores the default coefficients.
- Pipeline: two register stages, S1 and S2.
  - S1 registers, per lane: products r*cr, g*cg, b*cb (each WIDTH_P+COEF_W_P bits), the raw r/g/b values, and mode.
  - S2 registers, per lane, the final result:
    - mode 0: (sum + 2^(COEF_W_P-1)) >> COEF_W_P, saturated to 2^WIDTH_P-1. The sum is carried at WIDTH_P+COEF_W_P+2 bits.
    - mode 1: r. mode 2: g. mode 3: max(r,g,b).
- Latency: exactly 2 cycles from an accepted beat to valid_o when unstalled. Throughput is 1 beat per cycle.
- Handshake:
  - Global advance: en = !valid_s2 || ready_i; ready_o = en.
  - On en, S1 takes the input beat and S2 takes S1.
  - While valid_o && !ready_i, gray_o and valid_o hold stable, S1 holds, and ready_o=0.
  - Bubbles collapse: if S2 is empty, S1 advances regardless of ready_i.
  - Beat order is preserved; no beat is dropped or duplicated.
  - valid_i high without ready_o does not accept the beat. The source holds its data (standard rule).
- Coefficients:
  - coef_load_i updates the active coefficient registers at the clock edge.
  - A beat accepted in the same cycle as coef_load_i uses the OLD coefficients. Beats accepted on later cycles use the new ones.
  - Beats already in flight are unaffected, because S1 stores products, not coefficients.
  - Loading is legal at any time, including mid-stall.
- Lanes: fully independent datapaths sharing one valid/ready and one mode.
- busy_o = valid_s1 || valid_s2.

Optional Feature:
- Macro: RGB2GRAY_PIPE_SKID_EN.
- Defined: a 2-entry skid buffer is added after S2.
  - ready_o becomes a registered signal (!skid_full) with no combinational path from ready_i.
  - Latency is 2 cycles when the skid buffer is empty (bypassed); otherwise beats drain in order.
  - Up to 2 extra beats are absorbed after ready_i falls.
  - busy_o also covers the skid entries.
- Undefined: behaviour exactly as above. ready_o is combinational from ready_i.

Test Plan:
- Defaults:
  - Stimulus: reset, mode 0, r=g=b=200, ready_i=1.
  - Response: gray_o=200 on the 2nd cycle after accept.
  - Stimulus: r=255, g=0, b=0.
  - Response: gray_o=77.
- Saturation and rounding:
  - Stimulus: load coefs 255/255/255; r=g=b=255.
  - Response: gray_o=255.
  - Stimulus: coefs 128/0/0, r=3.
  - Response: gray_o=2 (rounding (384+128)>>8).
- Backpressure:
  - Stimulus: stream beats r=g=b=1..6; ready_i=0 for cycles 3-7.
  - Response: gray_o holds during the stall; ready_o=0 while S2 is full; outputs are 1..6 in order, no loss or duplicate.
- Coefficient timing:
  - Stimulus: coef_load_i (0/256-1/0) in the same cycle as accepting beat A; beat B accepted next cycle; both with g=100, r=b=0.
  - Response: A uses defaults (59); B uses new coefs (100).
- Modes and lanes (LANES_P=4):
  - Stimulus: mode 3, lanes (10,20,30), (90,5,5), (0,0,0), (255,1,2).
  - Response: gray lanes 30, 90, 0, 255.
  - Stimulus: mode 1.
  - Response: the red values.
- Reset mid-stream:
  - Stimulus: assert rstn_i low with S1 and S2 full, after a coef load.
  - Response: valid_o=0 and busy_o=0 immediately; after release, r=255, g=b=0 gives 77.
